// File: rtl/fsa_header_seq.sv
// fsa_header_seq: per-frame sequencer running a reference pass, a scan pass, then capturing left/right header results.
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   start, img_width               frame request and its column count (accepted only in IDLE)
//   busy                           high from accepted start until the result handshake
//   rd_en, rd_x, hM3, hM2          column read strobe, column index, reference/scan phase flags
//   wfirst, wlast                  first/last column markers qualified by rd_en
//   det_lft_*, det_rt_*            detector results, captured once after the pipeline drains
//   res_valid, res_ready, res_*    captured result presented on a valid/ready handshake
//   err_width                      one-cycle pulse when a start is rejected for img_width<2
module fsa_header_seq #(
  parameter int C_IMG_WW = 12,
  parameter int C_RD_LAT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [C_IMG_WW-1:0] img_width,
  output logic                busy,
  output logic                rd_en,
  output logic [C_IMG_WW-1:0] rd_x,
  output logic                hM3,
  output logic                hM2,
  output logic                wfirst,
  output logic                wlast,
  input  logic                det_lft_valid,
  input  logic [C_IMG_WW-1:0] det_lft_x,
  input  logic                det_rt_valid,
  input  logic [C_IMG_WW-1:0] det_rt_x,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_lft_valid,
  output logic [C_IMG_WW-1:0] res_lft_x,
  output logic                res_rt_valid,
  output logic [C_IMG_WW-1:0] res_rt_x,
  output logic                err_width
);
  localparam int CW = $clog2(C_RD_LAT + 2);
  typedef enum logic [2:0] {IDLE, REF, GAP, SCAN, DRAIN, CAP, OUT} state_t;
  state_t              state;
  logic [C_IMG_WW-1:0] w;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                next_last;
  assign last      = rd_x == w - C_IMG_WW'(1);
  assign next_last = rd_x + C_IMG_WW'(1) == w - C_IMG_WW'(1);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      w             <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      rd_en         <= 1'b0;
      rd_x          <= '0;
      hM3           <= 1'b0;
      hM2           <= 1'b0;
      wfirst        <= 1'b0;
      wlast         <= 1'b0;
      res_valid     <= 1'b0;
      res_lft_valid <= 1'b0;
      res_lft_x     <= '0;
      res_rt_valid  <= 1'b0;
      res_rt_x      <= '0;
      err_width     <= 1'b0;
    end else begin
      err_width <= 1'b0;
      case (state)
        IDLE: begin
          if (start && img_width >= C_IMG_WW'(2)) begin
            state  <= REF;
            w      <= img_width;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
            hM3    <= 1'b1;
            rd_x   <= '0;
            wfirst <= 1'b1;
            wlast  <= 1'b0;
          end else if (start) begin
            err_width <= 1'b1;
          end
        end
        REF, SCAN: begin
          if (last) begin
            state  <= state == REF ? GAP : DRAIN;
            rd_en  <= 1'b0;
            hM3    <= 1'b0;
            hM2    <= 1'b0;
            wfirst <= 1'b0;
            wlast  <= 1'b0;
            rd_x   <= '0;
            cnt    <= '0;
          end else begin
            rd_x   <= rd_x + C_IMG_WW'(1);
            wfirst <= 1'b0;
            wlast  <= next_last;
          end
        end
        GAP: begin
          if (cnt == CW'(C_RD_LAT - 1)) begin
            state  <= SCAN;
            rd_en  <= 1'b1;
            hM2    <= 1'b1;
            rd_x   <= '0;
            wfirst <= 1'b1;
            wlast  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt == CW'(C_RD_LAT)) state <= CAP;
          else cnt <= cnt + CW'(1);
        end
        CAP: begin
          state         <= OUT;
          res_valid     <= 1'b1;
          res_lft_valid <= det_lft_valid;
          res_lft_x     <= det_lft_valid ? det_lft_x : '0;
          res_rt_valid  <= det_rt_valid;
          res_rt_x      <= det_rt_valid ? det_rt_x : '0;
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
